// File: rtl/ped_request.sv
`default_nettype none
// ============================================================================
// Module      : ped_request
// Description : Pedestrian push-button conditioner: synchronizer, debouncer,
//               press strobe, stuck detector and pending-request handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module ped_request #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STUCK_CYCLES    = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       req_ack,
    output logic       req,
    output logic       btn_db,
    output logic       btn_pulse,
    output logic       stuck,
    output logic [3:0] ovr_cnt
);

    localparam logic [15:0] c_db_last  = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] c_stuck    = 16'(STUCK_CYCLES);
    localparam logic [15:0] c_stuck_m1 = 16'(STUCK_CYCLES - 1);
    localparam logic [3:0]  c_ovr_max  = 4'd15;

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PENDING = 1'b1;

    logic        r_sync1;
    logic        r_sync2;
    logic [15:0] r_db_cnt;
    logic        r_btn_db;
    logic        r_btn_db_prev;
    logic [15:0] r_hold_cnt;
    logic        r_stuck;
    logic [0:0]  r_state;
    logic [3:0]  r_ovr_cnt;
    logic        w_pulse;

    assign w_pulse = r_btn_db & ~r_btn_db_prev;

    // Synchronizer and debouncer: a level change is accepted only after
    // DEBOUNCE_CYCLES consecutive disagreeing synchronized samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_db_cnt      <= 16'd0;
            r_btn_db      <= 1'b0;
            r_btn_db_prev <= 1'b0;
        end else begin
            r_sync1       <= btn_raw;
            r_sync2       <= r_sync1;
            r_btn_db_prev <= r_btn_db;
            if (r_sync2 != r_btn_db) begin
                if (r_db_cnt == c_db_last) begin
                    r_btn_db <= ~r_btn_db;
                    r_db_cnt <= 16'd0;
                end else begin
                    r_db_cnt <= r_db_cnt + 16'd1;
                end
            end else begin
                r_db_cnt <= 16'd0;
            end
        end
    end

    // Stuck detector: flag rises on the edge the hold count reaches the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_cnt <= 16'd0;
            r_stuck    <= 1'b0;
        end else if (r_btn_db) begin
            if (r_hold_cnt != c_stuck) begin
                r_hold_cnt <= r_hold_cnt + 16'd1;
            end
            if (r_hold_cnt == c_stuck_m1) begin
                r_stuck <= 1'b1;
            end
        end else begin
            r_hold_cnt <= 16'd0;
            r_stuck    <= 1'b0;
        end
    end

    // Request handshake; a press coinciding with an ack becomes the next request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ovr_cnt <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pulse) begin
                        r_state <= S_PENDING;
                    end
                end
                S_PENDING: begin
                    if (req_ack && !w_pulse) begin
                        r_state <= S_IDLE;
                    end else if (w_pulse && !req_ack && (r_ovr_cnt != c_ovr_max)) begin
                        r_ovr_cnt <= r_ovr_cnt + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req       = r_state;
    assign btn_db    = r_btn_db;
    assign btn_pulse = w_pulse;
    assign stuck     = r_stuck;
    assign ovr_cnt   = r_ovr_cnt;

endmodule
`default_nettype wire

// File: doc/ped_request.md
PED_REQUEST -- requirements
Module: ped_request

Purpose: upstream conditioner for the pedestrian push-button; its req output drives the btn input of the traffic-light datapath.

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable samples required to accept a button level change; legal range 2..65535.
REQ-002 Parameter STUCK_CYCLES, default 1024: debounced-high cycles after which the button is flagged stuck; legal range 2..65535 and greater than DEBOUNCE_CYCLES.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 btn_raw  input  1  asynchronous, bouncy push-button level (1 = pressed).
REQ-006 req_ack  input  1  downstream acknowledge; consumes a pending request.
REQ-007 req  output  1  registered pending-request flag, held until acknowledged.
REQ-008 btn_db  output  1  registered debounced button level.
REQ-009 btn_pulse  output  1  one-cycle strobe on each accepted press.
REQ-010 stuck  output  1  registered flag: button held at least STUCK_CYCLES.
REQ-011 ovr_cnt  output  4  saturating count of presses absorbed while a request was already pending.

Function
REQ-012 btn_raw SHALL pass through a 2-flop synchronizer; btn_sync is the second flop's output; no other logic samples btn_raw.
REQ-013 Debounce counter (16 bit) SHALL increment on each edge where btn_sync != btn_db, and clear to 0 on any edge where btn_sync == btn_db.
REQ-014 When btn_sync != btn_db and the counter equals DEBOUNCE_CYCLES-1, btn_db SHALL toggle and the counter SHALL clear on that edge.
REQ-015 Latency: with btn_raw stable, btn_db SHALL change exactly DEBOUNCE_CYCLES+2 rising edges after btn_raw changes; a bounce shorter than DEBOUNCE_CYCLES synchronized samples SHALL not change btn_db.
REQ-016 btn_pulse SHALL equal btn_db AND NOT btn_db_prev, where btn_db_prev is btn_db delayed one cycle, giving exactly one cycle per 0->1 transition of btn_db.
REQ-017 btn_pulse SHALL not assert on a btn_db 1->0 transition.
REQ-018 Hold counter (16 bit) SHALL increment each cycle btn_db==1, saturating at STUCK_CYCLES, and clear the cycle btn_db==0.
REQ-019 stuck SHALL be set on the edge the hold counter reaches STUCK_CYCLES and cleared on the edge after btn_db falls.
REQ-020 While stuck==1, btn_pulse SHALL still be generated normally; stuck is a status output only.
REQ-021 Request FSM states: IDLE (req=0), PENDING (req=1).
REQ-022 IDLE -> PENDING on an edge where btn_pulse==1; req_ack in IDLE SHALL be ignored.
REQ-023 PENDING -> IDLE on an edge where req_ack==1 and btn_pulse==0.
REQ-024 In PENDING, if btn_pulse==1 and req_ack==1 on the same edge, the FSM SHALL remain PENDING, so the new press becomes the next request; ovr_cnt is unchanged.
REQ-025 In PENDING, if btn_pulse==1 and req_ack==0, the FSM SHALL stay PENDING and ovr_cnt SHALL increment, saturating at 15.
REQ-026 req SHALL be a registered output of the FSM state: it rises one cycle after btn_pulse and falls one cycle after req_ack.
REQ-027 ovr_cnt SHALL clear only on reset.

Reset
REQ-028 While reset==1 at a rising edge, all of the following SHALL be cleared to 0: synchronizer flops, both counters, btn_db, btn_db_prev, stuck, ovr_cnt, and the FSM (IDLE).
REQ-029 Consequently, all outputs SHALL be 0 on the cycle after any reset edge.
REQ-030 Reset asserted mid-operation (PENDING, partial debounce count, stuck) SHALL abandon all state with no residual request.
REQ-031 After reset, a button already held SHALL be accepted as a new press after DEBOUNCE_CYCLES+2 edges.

Verification
REQ-032 DEBOUNCE_CYCLES=16: btn_raw 0->1, held -> btn_db=1 exactly 18 edges later; btn_pulse=1 for one cycle; req=1 the next cycle.
REQ-033 btn_raw high 10 cycles, then toggling every 5 cycles for 100 cycles, then low -> btn_db, btn_pulse, and req all remain 0.
REQ-034 req=1, three clean presses, no req_ack -> ovr_cnt=3 and req stays 1; then req_ack for one cycle -> req=0 on the next cycle.
REQ-035 PENDING with req_ack and btn_pulse on the same edge -> req stays 1, ovr_cnt unchanged; a second req_ack -> req=0.
REQ-036 STUCK_CYCLES=1024: hold button -> stuck=1 exactly 1024 cycles after btn_db rises; release -> stuck=0 the cycle after btn_db falls.
REQ-037 Assert reset while req=1, stuck=1, and ovr_cnt=15 -> all outputs 0 the next cycle; button still held -> a new btn_pulse 18 edges after reset deasserts.
